// File: rtl/disp_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_reg_pkg
// Description : Shared types and constants for the dispatcher register poller:
//               FSM state encoding, response status codes, default register
//               map and expected ID byte.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STATUS = 3'd1,
        ST_GAP       = 3'd2,
        ST_RD_COUNT  = 3'd3,
        ST_WR        = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OK          = 2'd0;
    localparam logic [1:0] RESP_NOT_READY   = 2'd1;
    localparam logic [1:0] RESP_ID_MISMATCH = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT     = 2'd3;

    localparam logic [31:0] DEF_STATUS_ADDR = 32'd0;
    localparam logic [31:0] DEF_COUNT_ADDR  = 32'd4;
    localparam logic [7:0]  DEF_ID_VALUE    = 8'h02;

endpackage : disp_reg_pkg
`default_nettype wire

// File: rtl/disp_reg_poller_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_reg_poller_if
// Description : Command, register-bus and response signals of the dispatcher
//               register poller. The master modport is the poller itself; the
//               slave modport is the sequencer/responder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_reg_poller_if;

    // Command from the sequencer
    logic        iCmdValid;
    logic        oCmdReady;
    logic        iCmdOp;
    logic [31:0] iCmdAddress;
    logic [31:0] iCmdData;

    // Register read channel
    logic [31:0] oReadAddress;
    logic        oReadValid;
    logic [31:0] iReadData;
    logic        iReadAck;

    // Register write channel
    logic [31:0] oWriteAddress;
    logic [31:0] oWriteData;
    logic        oWriteValid;
    logic        iWriteAck;

    // Result
    logic        oRespValid;
    logic [1:0]  oRespStatus;
    logic [31:0] oRespCount;

    modport master (
        input  iCmdValid, iCmdOp, iCmdAddress, iCmdData,
        input  iReadData, iReadAck, iWriteAck,
        output oCmdReady, oReadAddress, oReadValid,
        output oWriteAddress, oWriteData, oWriteValid,
        output oRespValid, oRespStatus, oRespCount
    );

    modport slave (
        output iCmdValid, iCmdOp, iCmdAddress, iCmdData,
        output iReadData, iReadAck, iWriteAck,
        input  oCmdReady, oReadAddress, oReadValid,
        input  oWriteAddress, oWriteData, oWriteValid,
        input  oRespValid, oRespStatus, oRespCount
    );

endinterface : disp_reg_poller_if
`default_nettype wire

// File: rtl/disp_reg_poller.sv
`default_nettype none
// ============================================================================
// Module      : disp_reg_poller
// Description : Register-bus initiator. Polls the dispatcher status register
//               until push-bundle-ready, then reads the queue count; or
//               performs a single register write. Returns one status/count.
//               Optional ack timeout built when DISP_REG_POLLER_TIMEOUT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_reg_poller
    import disp_reg_pkg::*;
#(
    parameter logic [7:0]  ID_VALUE       = DEF_ID_VALUE,
    parameter logic [31:0] STATUS_ADDR    = DEF_STATUS_ADDR,
    parameter logic [31:0] COUNT_ADDR     = DEF_COUNT_ADDR,
    parameter int unsigned MAX_POLLS      = 16,
    parameter int unsigned RETRY_GAP      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic         iClock,
    input  wire logic         iReset,
    disp_reg_poller_if.master bus
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  w_status;
    logic [31:0] w_count;
    logic [7:0]  w_poll_next;
    logic        w_tmo_expired;

    logic [7:0]  r_polls;
    logic [7:0]  r_gap;
    logic        r_read_valid;
    logic [31:0] r_read_addr;
    logic        r_write_valid;
    logic [31:0] r_write_addr;
    logic [31:0] r_write_data;
    logic        r_resp_valid;
    logic [1:0]  r_resp_status;
    logic [31:0] r_resp_count;

    assign w_poll_next = r_polls + 8'd1;

`ifdef DISP_REG_POLLER_TIMEOUT_EN
    logic [15:0] r_tmo;

    // Ack watchdog: reload when a request state is entered, count down otherwise
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_tmo <= 16'd0;
        end else if ((w_next != r_state) &&
                     ((w_next == ST_RD_STATUS) || (w_next == ST_RD_COUNT) || (w_next == ST_WR))) begin
            r_tmo <= 16'(TIMEOUT_CYCLES - 1);
        end else if (r_tmo != 16'd0) begin
            r_tmo <= r_tmo - 16'd1;
        end
    end

    assign w_tmo_expired = (r_tmo == 16'd0);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_tmo_expired    = 1'b0;
`endif

    // State register
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and result selection; an ack always wins over an expiring timer
    always_comb begin
        w_next   = r_state;
        w_status = RESP_OK;
        w_count  = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (bus.iCmdValid) begin
                    w_next = bus.iCmdOp ? ST_WR : ST_RD_STATUS;
                end
            end
            ST_RD_STATUS: begin
                if (bus.iReadAck) begin
                    if (bus.iReadData[31:24] != ID_VALUE) begin
                        w_next   = ST_RESP;
                        w_status = RESP_ID_MISMATCH;
                    end else if (bus.iReadData[0]) begin
                        w_next = ST_RD_COUNT;
                    end else if (w_poll_next == 8'(MAX_POLLS)) begin
                        w_next   = ST_RESP;
                        w_status = RESP_NOT_READY;
                    end else begin
                        w_next = ST_GAP;
                    end
                end else if (w_tmo_expired) begin
                    w_next   = ST_RESP;
                    w_status = RESP_TIMEOUT;
                end
            end
            ST_GAP: begin
                if (r_gap <= 8'd1) begin
                    w_next = ST_RD_STATUS;
                end
            end
            ST_RD_COUNT: begin
                if (bus.iReadAck) begin
                    w_next  = ST_RESP;
                    w_count = bus.iReadData;
                end else if (w_tmo_expired) begin
                    w_next   = ST_RESP;
                    w_status = RESP_TIMEOUT;
                end
            end
            ST_WR: begin
                if (bus.iWriteAck) begin
                    w_next = ST_RESP;
                end else if (w_tmo_expired) begin
                    w_next   = ST_RESP;
                    w_status = RESP_TIMEOUT;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Registered bus/result outputs, decoded from the upcoming state so they
    // line up with the state they belong to
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_polls       <= 8'd0;
            r_gap         <= 8'd0;
            r_read_valid  <= 1'b0;
            r_read_addr   <= 32'd0;
            r_write_valid <= 1'b0;
            r_write_addr  <= 32'd0;
            r_write_data  <= 32'd0;
            r_resp_valid  <= 1'b0;
            r_resp_status <= RESP_OK;
            r_resp_count  <= 32'd0;
        end else begin
            r_read_valid  <= (w_next == ST_RD_STATUS) || (w_next == ST_RD_COUNT);
            r_write_valid <= (w_next == ST_WR);
            r_resp_valid  <= (w_next == ST_RESP);

            if (w_next == ST_RD_STATUS) begin
                r_read_addr <= STATUS_ADDR;
            end else if (w_next == ST_RD_COUNT) begin
                r_read_addr <= COUNT_ADDR;
            end

            if ((r_state == ST_IDLE) && bus.iCmdValid && bus.iCmdOp) begin
                r_write_addr <= bus.iCmdAddress;
                r_write_data <= bus.iCmdData;
            end

            if (r_state == ST_IDLE) begin
                r_polls <= 8'd0;
            end else if ((r_state == ST_RD_STATUS) && bus.iReadAck) begin
                r_polls <= w_poll_next;
            end

            // RETRY_GAP of 0 still spends the single GAP cycle
            if ((w_next == ST_GAP) && (r_state != ST_GAP)) begin
                r_gap <= 8'(RETRY_GAP);
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - 8'd1;
            end

            if (w_next == ST_RESP) begin
                r_resp_status <= w_status;
                r_resp_count  <= w_count;
            end
        end
    end

    assign bus.oCmdReady     = (r_state == ST_IDLE);
    assign bus.oReadValid    = r_read_valid;
    assign bus.oReadAddress  = r_read_addr;
    assign bus.oWriteValid   = r_write_valid;
    assign bus.oWriteAddress = r_write_addr;
    assign bus.oWriteData    = r_write_data;
    assign bus.oRespValid    = r_resp_valid;
    assign bus.oRespStatus   = r_resp_status;
    assign bus.oRespCount    = r_resp_count;

endmodule : disp_reg_poller
`default_nettype wire

// File: doc/disp_reg_poller.md
# disp_reg_poller

Register-bus initiator that drives the dispatcher's register read/write port from the controller side. It accepts one command at a time from the local sequencer: either a poll of the dispatcher status/count registers or a single register write. It issues the bus transactions, waits for the responder's ack, and returns one result word with a status code. It sits between the command sequencer and the dispatcher register responder.

## Interface
- ID_VALUE, 8'h02: expected value of status register bits [31:24].
- STATUS_ADDR, 32'd0: address of the status register; bit 0 is push-bundle-ready.
- COUNT_ADDR, 32'd4: address of the SP queue-count register.
- MAX_POLLS, 16: status reads attempted before reporting not-ready; range 1..255.
- RETRY_GAP, 4: idle cycles between status re-reads; range 0..255.
- TIMEOUT_CYCLES, 255: cycles allowed for one ack; range 1..65535.
- iClock  in  1  clock; all logic on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iCmdValid  in  1  command present.
- oCmdReady  out  1  high only in IDLE.
- iCmdOp  in  1  0 = poll, 1 = write.
- iCmdAddress  in  32  write address (write op only).
- iCmdData  in  32  write data (write op only).
- oReadAddress  out  32  bus read address.
- oReadValid  out  1  bus read request.
- iReadData  in  32  bus read data; valid in the cycle iReadAck is high.
- iReadAck  in  1  read ack; may be combinational and permanently high.
- oWriteAddress  out  32  bus write address.
- oWriteData  out  32  bus write data.
- oWriteValid  out  1  bus write request.
- iWriteAck  in  1  write ack.
- oRespValid  out  1  one-cycle result strobe.
- oRespStatus  out  2  0 OK, 1 NOT_READY, 2 ID_MISMATCH, 3 TIMEOUT.
- oRespCount  out  32  queue count; 0 unless status is OK on a poll.

## Operation
- States: IDLE, RD_STATUS, GAP, RD_COUNT, WR, RESP.
- IDLE:
  - A command is accepted when iCmdValid && oCmdReady.
  - Op 0 goes to RD_STATUS and clears the poll counter. Op 1 latches address and data, then goes to WR.
- RD_STATUS: oReadValid=1, oReadAddress=STATUS_ADDR. On iReadAck:
  - If iReadData[31:24] != ID_VALUE: status 2, go to RESP.
  - Else if iReadData[0]=1: go to RD_COUNT.
  - Else increment the poll counter. If it reaches MAX_POLLS: status 1, go to RESP. Otherwise go to GAP.
- GAP: count down RETRY_GAP cycles, then return to RD_STATUS. RETRY_GAP=0 returns to RD_STATUS on the next cycle.
- RD_COUNT: oReadValid=1, oReadAddress=COUNT_ADDR. On iReadAck: capture iReadData into the count, status 0, go to RESP.
- WR: oWriteValid=1 with the latched address and data. On iWriteAck: status 0, go to RESP.
- RESP: oRespValid=1 for exactly one cycle, then IDLE. Result outputs hold their values until the next RESP.
- Valid/ack rule: a request stays asserted with stable address and data until the ack cycle. It drops in the cycle after the ack. An ack seen outside an active request is ignored.
- Reset mid-operation: all state is abandoned immediately with no response. Outputs return to reset values.

## Timing
- Reset values: oCmdReady=1 (IDLE), oReadValid=0, oWriteValid=0, oReadAddress=0, oWriteAddress=0, oWriteData=0, oRespValid=0, oRespStatus=0, oRespCount=0.
- All outputs are registered except oCmdReady, which is decoded from the state register.
- Poll with ready on the first read and iReadAck tied high:
  - Accept at cycle 0, then status read at cycle 1, count read at cycle 2, oRespValid at cycle 3.
- Write with immediate ack: accept at cycle 0, WR at cycle 1, oRespValid at cycle 2.
- A new command can be accepted in the cycle after RESP.
- Timeout counter: reloads on entry to RD_STATUS, RD_COUNT or WR, and decrements each cycle without an ack. At zero: request drops, status 3, go to RESP. An ack arriving in the expiry cycle wins over the timeout.

## Configuration
- DISP_REG_POLLER_TIMEOUT_EN defined: the timeout counter is built and status 3 is reachable.
- Macro undefined: the counter is removed. The block waits indefinitely for an ack, status 3 never occurs, and the TIMEOUT_CYCLES parameter is ignored.

## Structure
- Shared package disp_reg_pkg holds:
  - the state enum;
  - response-status constants RESP_OK, RESP_NOT_READY, RESP_ID_MISMATCH, RESP_TIMEOUT;
  - the default register addresses and ID_VALUE.
- No sub-module. The timeout counter stays inline under the macro guard.

## Test plan
- Responder returns 32'h02000001 at address 0 and 32'd37 at address 4, ack tied high; poll -> oRespValid at cycle 3, status 0, count 37.
- Status bit 0 is low for three reads then high, RETRY_GAP=4 -> four status reads separated by 4-cycle gaps, then the count read, status 0.
- Status stays 32'h02000000 with MAX_POLLS=16 -> exactly 16 status reads, status 1, count 0.
- Status returns 32'h05000001 -> one read, status 2, no count read issued.
- Write to 32'h8 with iWriteAck held low, macro defined, TIMEOUT_CYCLES=10 -> oWriteValid held 10 cycles, then status 3. Macro undefined -> no response until the ack arrives.
- Assert iReset during GAP of a poll -> all outputs return to reset values and no oRespValid is produced; a subsequent poll completes normally.
